intensity_silencer: RTL
=======================

INTENSITY_SILENCER -- requirements
Module: intensity_silencer

Interface
REQ-001 Parameter DEPTH, default 249, SHALL be the number of transducer channels per frame.
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 RST  input  1  SHALL be the reset, asynchronous and active-high.
REQ-004 DIN_VALID  input  1  SHALL qualify INTENSITY_IN; one frame is DEPTH consecutive high cycles, driven by the modulation multiplier DOUT_VALID.
REQ-005 INTENSITY_IN  input  8  SHALL be the target intensity for the current channel.
REQ-006 STEP  input  8  SHALL be the maximum per-frame intensity change; 0 means unlimited.
REQ-007 BYPASS  input  1  SHALL force output equal to the target when high.
REQ-008 INTENSITY_OUT  output  8  SHALL be the silenced intensity.
REQ-009 DOUT_VALID  output  1  SHALL qualify INTENSITY_OUT.
REQ-010 DEBUG_CH  output  $clog2(DEPTH)  SHALL be the current channel index.

Function
REQ-011 Channel counter ch SHALL be 0 on the first DIN_VALID cycle of each frame and increment by 1 per DIN_VALID cycle.
REQ-012 ch SHALL return to 0 on any cycle with DIN_VALID low, which is the frame boundary.
REQ-013 If DIN_VALID stays high past DEPTH cycles, ch SHALL wrap from DEPTH-1 to 0 and treat the next cycle as channel 0.
REQ-014 Per-channel state cur[0..DEPTH-1], 8 bits each, SHALL hold the last output intensity of each channel.
REQ-015 STEP and BYPASS SHALL be sampled on the channel-0 cycle and held for that whole frame.
REQ-016 The block SHALL compute diff = INTENSITY_IN - cur[ch] as a 9-bit signed value.
REQ-017 new SHALL equal INTENSITY_IN if BYPASS is set, STEP is 0, or |diff| <= STEP.
REQ-018 Otherwise new SHALL equal cur[ch] + STEP when diff > 0, and cur[ch] - STEP when diff < 0.
REQ-019 new SHALL never under- or overflow 0..255; the result is clamped by construction through REQ-017.
REQ-020 Latency SHALL be 1 cycle: INTENSITY_OUT = new and DOUT_VALID = 1 on the cycle after the DIN_VALID cycle.
REQ-021 On that same edge, new SHALL be written back to cur[ch].
REQ-022 A read of cur[ch] SHALL always observe the write from a prior frame; the same channel is never read and written in one cycle within a frame.
REQ-023 DOUT_VALID SHALL equal DIN_VALID delayed by exactly 1 cycle, with no gaps inserted or removed.
REQ-024 INTENSITY_OUT SHALL hold its last value while DOUT_VALID is low.
REQ-025 DEBUG_CH SHALL equal ch of the input cycle.

Reset
REQ-026 On RST high, immediately and regardless of CLK: cur[] = 0, ch = 0, INTENSITY_OUT = 0, DOUT_VALID = 0, and sampled STEP = 0, BYPASS = 0.
REQ-027 RST asserted mid-frame SHALL abort the frame.
REQ-028 After RST deasserts, the first DIN_VALID cycle SHALL be treated as channel 0.
REQ-029 No output SHALL assert on the edge on which RST deasserts.

Verification
REQ-030 Ramp up: reset, STEP=16, 3 frames with all targets 100 -> channel outputs 16, 32, 48 in frames 1-3; each frame is DEPTH valid cycles, each 1 cycle late.
REQ-031 Convergence and ramp down: STEP=16, targets 100 until output is 100, then targets 10 -> next frames output 84, 68, ...; the last step lands exactly on 10 with no overshoot.
REQ-032 Bypass and unlimited step: BYPASS=1, or STEP=0, with target 200 from cur 0 -> output 200 in the first frame.
REQ-033 Per-channel independence: STEP=8, channel 0 target 255 and channel 5 target 0 from cur 0 -> ch0 = 8, ch5 = 0; other channels unchanged.
REQ-034 Mid-frame changes: change STEP and drop DIN_VALID mid-frame -> the old STEP is used for the rest of the frame; ch restarts at 0 on the next valid cycle; DOUT_VALID gap equals the input gap.
REQ-035 Async reset: assert RST mid-frame between clock edges -> outputs go to 0 without waiting for a clock edge; the next frame starts from cur = 0.

Source files
------------

// File: rtl/intensity_silencer_if.sv
// intensity_silencer_if: frame-valid data bundle between the modulation multiplier, the silencer and its consumer
interface intensity_silencer_if #(parameter int DEPTH = 249);
   localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic          din_valid;
   logic [7:0]    intensity_in;
   logic [7:0]    step;
   logic          bypass;
   logic [7:0]    intensity_out;
   logic          dout_valid;
   logic [CW-1:0] debug_ch;
   modport master (output din_valid, intensity_in, step, bypass, input intensity_out, dout_valid, debug_ch);
   modport slave (input din_valid, intensity_in, step, bypass, output intensity_out, dout_valid, debug_ch);
endinterface

// File: rtl/intensity_silencer.sv
// intensity_silencer: per-channel slew limiter that moves each channel's intensity toward its target by at most STEP per frame
module intensity_silencer #(parameter int DEPTH = 249) (
   input logic clk,
   input logic rst,
   intensity_silencer_if.slave bus
);
   localparam int CW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [CW-1:0] cnt, ch;
   logic [7:0]    cur [DEPTH];
   logic [7:0]    step_q, st, c, nxt;
   logic          byp_q, byp, first;
   logic [8:0]    diff, mag;
   // channel-0 cycle uses the live STEP/BYPASS so the sampled values apply to the whole frame
   always_comb begin
      ch = bus.din_valid ? cnt : '0;
      first = bus.din_valid && ch == '0;
      st = first ? bus.step : step_q;
      byp = first ? bus.bypass : byp_q;
      c = cur[ch];
      diff = {1'b0, bus.intensity_in} - {1'b0, c};
      mag = diff[8] ? -diff : diff;
      nxt = (byp || st == '0 || mag <= {1'b0, st}) ? bus.intensity_in : diff[8] ? c - st : c + st;
   end
   assign bus.debug_ch = ch;
   // channel counter: restarts at every invalid cycle and wraps after DEPTH valid cycles
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else cnt <= (!bus.din_valid || cnt == CW'(DEPTH - 1)) ? '0 : cnt + 1'b1;
   // frame-wide STEP/BYPASS capture on channel 0
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         step_q <= '0;
         byp_q <= 1'b0;
      end else if (first) begin
         step_q <= bus.step;
         byp_q <= bus.bypass;
      end
   // per-channel history, written on the same edge the result is presented
   always_ff @(posedge clk or posedge rst)
      if (rst) for (int i = 0; i < DEPTH; i++) cur[i] <= '0;
      else if (bus.din_valid) cur[ch] <= nxt;
   // one-cycle output register; intensity holds while invalid
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bus.intensity_out <= '0;
         bus.dout_valid <= 1'b0;
      end else begin
         bus.dout_valid <= bus.din_valid;
         if (bus.din_valid) bus.intensity_out <= nxt;
      end
endmodule
